// File: rtl/bitrev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_pkg
// Description : Shared types, defaults and the k-bit index reverse helper
//               for the bit-reversal reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package bitrev_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    localparam int DEFAULT_KMAX = 10;
    // Widest index the reverse helper handles; KMAX must not exceed it.
    localparam int REV_W        = 16;

    // Reverse the low k bits of idx; bits at or above k are dropped.
    function automatic logic [REV_W-1:0] rev_k(input logic [REV_W-1:0] idx,
                                               input logic [4:0]       k);
        logic [REV_W-1:0] w_full;
        for (int i = 0; i < REV_W; i++) begin
            w_full[i] = idx[REV_W-1-i];
        end
        return w_full >> (5'(REV_W) - k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitrev_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_cfg_if
// Description : Streaming input/output and per-frame config bundle of the
//               bit-reversal reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bitrev_cfg_if #(
    parameter int KMAX = bitrev_pkg::DEFAULT_KMAX,
    parameter int DW   = 32
);
    localparam int KW = $clog2(KMAX + 1);

    logic [KW-1:0] cfg_k_i;
    logic          cfg_bypass_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i;

    // Block side.
    modport slave (
        input  cfg_k_i, cfg_bypass_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    // Producer/consumer side.
    modport master (
        output cfg_k_i, cfg_bypass_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );

endinterface
`default_nettype wire

// File: rtl/bitrev_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_bank_ram
// Description : Simple dual-port storage for both banks; address MSB selects
//               the bank. One write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module bitrev_bank_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Read data only moves on i_re, so a stalled read keeps its word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bitrev_cfg.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_cfg
// Description : Ping-pong frame buffer that re-emits each frame of 2^k words
//               in natural or bit-reversed order, k latched per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module bitrev_cfg
    import bitrev_pkg::*;
#(
    parameter int KMAX = DEFAULT_KMAX,
    parameter int DW   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    bitrev_cfg_if.slave bus
);
    localparam int KW = $clog2(KMAX + 1);
    localparam int AW = KMAX + 1;

    function automatic logic [KMAX-1:0] f_last_idx(input logic [KW-1:0] k);
        return KMAX'((AW'(1) << k) - AW'(1));
    endfunction

    // Bank bookkeeping and per-bank latched config
    bank_state_e     r_bank_st     [2];
    bank_state_e     w_bank_st_nxt [2];
    logic [KW-1:0]   r_cfg_k       [2];
    logic            r_cfg_byp     [2];

    // Writer
    logic            r_wr_ptr;
    logic [KMAX-1:0] r_wr_idx;
    logic            w_wr_ready;
    logic            w_wr_fire;
    logic            w_wr_first;
    logic            w_wr_last;
    logic [KW-1:0]   w_cfg_k_clamp;
    logic [KW-1:0]   w_wr_k;

    // Reader: issue side walks ahead of the release side by the pipeline depth
    logic            r_iss_ptr;
    logic [KMAX-1:0] r_iss_idx;
    logic            r_iss_active;
    logic            r_rd_ptr;
    logic [KW-1:0]   w_iss_k;
    logic            w_iss_byp;
    logic            w_iss_avail;
    logic            w_iss_fire;
    logic            w_iss_last;
    logic [KMAX-1:0] w_rd_idx;

    // Read pipeline: RAM stage then output skid register
    logic            r_s1_valid;
    logic            r_s1_last;
    logic            r_valid_o;
    logic            r_last_o;
    logic [DW-1:0]   r_data_o;
    logic [DW-1:0]   w_rdata;
    logic            w_out_ready;
    logic            w_s1_ready;
    logic            w_rel;

    assign w_wr_ready    = !rst_i && ((r_bank_st[r_wr_ptr] == BANK_EMPTY) ||
                                      (r_bank_st[r_wr_ptr] == BANK_FILLING));
    assign w_wr_fire     = bus.valid_i && w_wr_ready;
    assign w_wr_first    = (r_bank_st[r_wr_ptr] == BANK_EMPTY);
    assign w_cfg_k_clamp = (bus.cfg_k_i > KW'(KMAX)) ? KW'(KMAX) : bus.cfg_k_i;
    assign w_wr_k        = w_wr_first ? w_cfg_k_clamp : r_cfg_k[r_wr_ptr];
    assign w_wr_last     = (r_wr_idx == f_last_idx(w_wr_k));

    assign w_iss_k     = r_cfg_k[r_iss_ptr];
    assign w_iss_byp   = r_cfg_byp[r_iss_ptr];
    // A DRAINING bank that is not active is waiting only for its release.
    assign w_iss_avail = r_iss_active || (r_bank_st[r_iss_ptr] == BANK_FULL);
    assign w_out_ready = !r_valid_o || bus.ready_i;
    assign w_s1_ready  = !r_s1_valid || w_out_ready;
    assign w_iss_fire  = w_iss_avail && w_s1_ready;
    assign w_iss_last  = (r_iss_idx == f_last_idx(w_iss_k));
    assign w_rd_idx    = w_iss_byp ? r_iss_idx
                                   : KMAX'(rev_k(REV_W'(r_iss_idx), 5'(w_iss_k)));
    assign w_rel       = r_valid_o && bus.ready_i && r_last_o;

    // Writer, issuer and releaser never target a bank in the same state,
    // so their updates are disjoint and may all land on one edge.
    always_comb begin
        w_bank_st_nxt[0] = r_bank_st[0];
        w_bank_st_nxt[1] = r_bank_st[1];
        if (w_wr_fire) begin
            w_bank_st_nxt[r_wr_ptr] = w_wr_last ? BANK_FULL : BANK_FILLING;
        end
        if (w_iss_fire && !r_iss_active) begin
            w_bank_st_nxt[r_iss_ptr] = BANK_DRAINING;
        end
        if (w_rel) begin
            w_bank_st_nxt[r_rd_ptr] = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_cfg_k[0]   <= '0;
            r_cfg_k[1]   <= '0;
            r_cfg_byp[0] <= 1'b0;
            r_cfg_byp[1] <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_wr_idx     <= '0;
            r_iss_ptr    <= 1'b0;
            r_iss_idx    <= '0;
            r_iss_active <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_valid_o    <= 1'b0;
            r_last_o     <= 1'b0;
            r_data_o     <= '0;
        end else begin
            r_bank_st[0] <= w_bank_st_nxt[0];
            r_bank_st[1] <= w_bank_st_nxt[1];

            if (w_wr_fire) begin
                if (w_wr_first) begin
                    r_cfg_k[r_wr_ptr]   <= w_cfg_k_clamp;
                    r_cfg_byp[r_wr_ptr] <= bus.cfg_bypass_i;
                end
                if (w_wr_last) begin
                    r_wr_idx <= '0;
                    r_wr_ptr <= ~r_wr_ptr;
                end else begin
                    r_wr_idx <= r_wr_idx + KMAX'(1);
                end
            end

            if (w_iss_fire) begin
                if (w_iss_last) begin
                    r_iss_idx    <= '0;
                    r_iss_ptr    <= ~r_iss_ptr;
                    r_iss_active <= 1'b0;
                end else begin
                    r_iss_idx    <= r_iss_idx + KMAX'(1);
                    r_iss_active <= 1'b1;
                end
            end

            if (w_s1_ready) begin
                r_s1_valid <= w_iss_fire;
                r_s1_last  <= w_iss_fire && w_iss_last;
            end

            if (w_out_ready) begin
                r_valid_o <= r_s1_valid;
                r_last_o  <= r_s1_valid && r_s1_last;
                if (r_s1_valid) begin
                    r_data_o <= w_rdata;
                end
            end

            if (w_rel) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    bitrev_bank_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .i_clk   (clk_i),
        .i_we    (w_wr_fire),
        .i_waddr ({r_wr_ptr, r_wr_idx}),
        .i_wdata (bus.data_i),
        .i_re    (w_iss_fire),
        .i_raddr ({r_iss_ptr, w_rd_idx}),
        .o_rdata (w_rdata)
    );

    assign bus.ready_o = w_wr_ready;
    assign bus.valid_o = r_valid_o;
    assign bus.data_o  = r_data_o;
    assign bus.last_o  = r_last_o;

endmodule
`default_nettype wire
